// File: rtl/feistel_decrypt.sv
// Blowfish 16-round Feistel decryption core reading P-array and S-boxes from two read-only SRAMs.
// Optional FEISTEL_DECRYPT_BIDIR_EN adds an `encrypt` input that runs the same engine forwards.
module feistel_decrypt #(
    parameter int P_ARRAY_OFFSET = 4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] L,
    input  logic [31:0] R,
`ifdef FEISTEL_DECRYPT_BIDIR_EN
    input  logic        encrypt,
`endif
    output logic [11:0] addr_a,
    input  logic [31:0] data_a,
    output logic        cs_a_l,
    output logic        we_a_l,
    output logic        oe_a_l,
    output logic [11:0] addr_b,
    input  logic [31:0] data_b,
    output logic        cs_b_l,
    output logic        we_b_l,
    output logic        oe_b_l,
    output logic [31:0] resultL,
    output logic [31:0] resultR,
    output logic        done
);

    localparam logic [11:0] OFF = 12'(P_ARRAY_OFFSET);

    typedef enum logic [2:0] {WAIT, PXOR, SB01, SB23, FMIX, FINAL, DONE} state_t;

    state_t      state;
    logic [31:0] lr, rr, f_r;
    logic [4:0]  rc;
    logic [4:0]  next_rc;
    logic        more_rounds;
    logic        rd_a, rd_b;
    logic        enc_r;
    logic        start_enc;

`ifdef FEISTEL_DECRYPT_BIDIR_EN
    assign start_enc = encrypt;
`else
    assign enc_r     = 1'b0;
    assign start_enc = 1'b0;
`endif

    // Decrypt walks P17 down to P2, encrypt walks P0 up to P15.
    assign next_rc     = enc_r ? rc + 5'd1 : rc - 5'd1;
    assign more_rounds = enc_r ? (rc < 5'd15) : (rc > 5'd2);

    always_comb begin
        rd_a   = 1'b0;
        rd_b   = 1'b0;
        addr_a = 12'd0;
        addr_b = 12'd0;
        case (state)
            WAIT: begin
                if (start) begin
                    rd_a   = 1'b1;
                    addr_a = start_enc ? OFF : OFF + 12'd17;
                end
            end
            SB01: begin
                rd_a   = 1'b1;
                rd_b   = 1'b1;
                addr_a = {4'd0, lr[31:24]};
                addr_b = 12'd256 + {4'd0, lr[23:16]};
            end
            SB23: begin
                rd_a   = 1'b1;
                rd_b   = 1'b1;
                addr_a = 12'd512 + {4'd0, lr[15:8]};
                addr_b = 12'd768 + {4'd0, lr[7:0]};
            end
            FMIX: begin
                rd_a = 1'b1;
                if (more_rounds) begin
                    addr_a = OFF + {7'd0, next_rc};
                end else begin
                    rd_b   = 1'b1;
                    addr_a = enc_r ? OFF + 12'd16 : OFF + 12'd1;
                    addr_b = enc_r ? OFF + 12'd17 : OFF;
                end
            end
            default: ;
        endcase
    end

    assign cs_a_l = ~rd_a;
    assign oe_a_l = ~rd_a;
    assign we_a_l = 1'b1;
    assign cs_b_l = ~rd_b;
    assign oe_b_l = ~rd_b;
    assign we_b_l = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= WAIT;
            lr      <= 32'd0;
            rr      <= 32'd0;
            f_r     <= 32'd0;
            rc      <= 5'd0;
            resultL <= 32'd0;
            resultR <= 32'd0;
            done    <= 1'b0;
`ifdef FEISTEL_DECRYPT_BIDIR_EN
            enc_r   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                WAIT: begin
                    if (start) begin
                        lr    <= L;
                        rr    <= R;
                        rc    <= start_enc ? 5'd0 : 5'd17;
`ifdef FEISTEL_DECRYPT_BIDIR_EN
                        enc_r <= encrypt;
`endif
                        state <= PXOR;
                    end
                end
                PXOR: begin
                    lr    <= lr ^ data_a;
                    state <= SB01;
                end
                SB01: state <= SB23;
                SB23: begin
                    f_r   <= data_a + data_b;
                    state <= FMIX;
                end
                FMIX: begin
                    lr <= rr ^ ((f_r ^ data_a) + data_b);
                    rr <= lr;
                    if (more_rounds) begin
                        rc    <= next_rc;
                        state <= PXOR;
                    end else begin
                        state <= FINAL;
                    end
                end
                // Output pairing undoes the swap performed by the last FMIX.
                FINAL: begin
                    resultR <= lr ^ data_a;
                    resultL <= rr ^ data_b;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE:    state <= WAIT;
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_feistel_decrypt.sv
// Self-checking bench for feistel_decrypt: SRAM models, Blowfish reference model, scoreboard.
// Define FEISTEL_DECRYPT_BIDIR_EN to also exercise the encrypt direction.
module tb_feistel_decrypt;

    localparam int OFF = 4000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] L_in, R_in;
    logic        encrypt;
    logic [11:0] addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic        cs_a_l, we_a_l, oe_a_l, cs_b_l, we_b_l, oe_b_l;
    logic [31:0] resultL, resultR;
    logic        done;

    logic [31:0] mem [4096];
    logic [63:0] exp_q [$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    feistel_decrypt #(.P_ARRAY_OFFSET(OFF)) dut (
        .clk(clk), .reset(reset), .start(start), .L(L_in), .R(R_in),
`ifdef FEISTEL_DECRYPT_BIDIR_EN
        .encrypt(encrypt),
`endif
        .addr_a(addr_a), .data_a(data_a), .cs_a_l(cs_a_l), .we_a_l(we_a_l), .oe_a_l(oe_a_l),
        .addr_b(addr_b), .data_b(data_b), .cs_b_l(cs_b_l), .we_b_l(we_b_l), .oe_b_l(oe_b_l),
        .resultL(resultL), .resultR(resultR), .done(done)
    );

    // Both SRAMs hold the same image; unselected cycles return garbage.
    always @(posedge clk) begin
        data_a <= !cs_a_l ? mem[addr_a] : $urandom;
        data_b <= !cs_b_l ? mem[addr_b] : $urandom;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        check("we_a", {63'd0, we_a_l}, 64'd1);
        check("we_b", {63'd0, we_b_l}, 64'd1);
        check("oe_a", {63'd0, oe_a_l}, {63'd0, cs_a_l});
        check("oe_b", {63'd0, oe_b_l}, {63'd0, cs_b_l});
        if (cs_a_l) check("idle_addr_a", {52'd0, addr_a}, 64'd0);
        if (cs_b_l) check("idle_addr_b", {52'd0, addr_b}, 64'd0);
    end

    function automatic logic [31:0] f_fn(input logic [31:0] x);
        return ((mem[x[31:24]] + mem[256 + x[23:16]]) ^ mem[512 + x[15:8]]) + mem[768 + x[7:0]];
    endfunction

    function automatic logic [63:0] model_decrypt(input logic [31:0] l, input logic [31:0] r);
        logic [31:0] t;
        for (int i = 17; i >= 2; i--) begin
            l = l ^ mem[OFF + i];
            r = r ^ f_fn(l);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        r = r ^ mem[OFF + 1];
        l = l ^ mem[OFF + 0];
        return {l, r};
    endfunction

    function automatic logic [63:0] model_encrypt(input logic [31:0] l, input logic [31:0] r);
        logic [31:0] t;
        for (int i = 0; i <= 15; i++) begin
            l = l ^ mem[OFF + i];
            r = r ^ f_fn(l);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        r = r ^ mem[OFF + 16];
        l = l ^ mem[OFF + 17];
        return {l, r};
    endfunction

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 4096; i++) mem[i] = rnd ? $urandom : 32'd0;
    endtask

    // Cycle 0 is the start cycle; returns the cycle in which done was seen (-1 on timeout).
    task automatic run_block(input logic [31:0] l, input logic [31:0] r, input bit enc,
                             input bit trace, input bit extra, output int done_cyc);
        bit seen = 0;
        done_cyc = -1;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1;
            start   = (c == 0) || (extra && (c == 10 || c == 66));
            encrypt = enc;
            if (c == 0) begin
                L_in = l;
                R_in = r;
            end else begin
                L_in = $urandom;
                R_in = $urandom;
            end
            @(negedge clk);
            if (trace) begin
                if (c == 0)  check("trace_c0",  {52'd0, addr_a}, 64'd4017);
                if (c == 2)  check("trace_c2",  {40'd0, addr_a, addr_b}, {40'd0, 12'd0, 12'd256});
                if (c == 3)  check("trace_c3",  {40'd0, addr_a, addr_b}, {40'd0, 12'd512, 12'd768});
                if (c == 4)  check("trace_c4",  {52'd0, addr_a}, 64'd4016);
                if (c == 64) check("trace_c64", {40'd0, addr_a, addr_b}, {40'd0, 12'd4001, 12'd4000});
            end
            if (done) begin
                seen     = 1;
                done_cyc = c;
            end
        end
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic block_and_score(input string tag, input logic [31:0] l, input logic [31:0] r,
                                   input bit enc, input bit trace, input bit extra);
        int dc;
        run_block(l, r, enc, trace, extra, dc);
        check({tag, "_done_cycle"}, 64'(dc), 64'd66);
        if (exp_q.size() > 0) check({tag, "_result"}, {resultL, resultR}, exp_q.pop_front());
        else check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
    endtask

    initial begin
        logic [31:0] l, r;
        logic [63:0] ct;
        int dc;
        bit seen;

        reset = 1; start = 0; encrypt = 0; L_in = 0; R_in = 0;
        fill_mem(0);
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_results", {resultL, resultR}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_cs", {62'd0, cs_a_l, cs_b_l}, 64'd3);

        exp_q.push_back(model_decrypt(32'd0, 32'd0));
        block_and_score("trace_zero", 32'd0, 32'd0, 0, 1, 0);

        exp_q.push_back({32'h89ABCDEF, 32'h01234567});
        block_and_score("zero_mem", 32'h01234567, 32'h89ABCDEF, 0, 0, 0);

        mem[OFF + 17] = 32'hFFFFFFFF;
        exp_q.push_back({32'h89ABCDEF, 32'hFEDCBA98});
        block_and_score("p17_ones", 32'h01234567, 32'h89ABCDEF, 0, 0, 0);

        fill_mem(1);
        for (int i = 0; i < 100; i++) begin
            l = $urandom;
            r = $urandom;
            if (i % 2 == 1) begin
                ct = model_encrypt(l, r);
                exp_q.push_back({l, r});
                block_and_score("roundtrip", ct[63:32], ct[31:0], 0, 0, 0);
            end else begin
                exp_q.push_back(model_decrypt(l, r));
                block_and_score("rand", l, r, 0, 0, 0);
            end
        end

        l = $urandom; r = $urandom;
        exp_q.push_back(model_decrypt(l, r));
        block_and_score("extra_start", l, r, 0, 0, 1);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("extra_start_no_second_done", {63'd0, seen}, 64'd0);
        check("extra_start_held", {resultL, resultR}, model_decrypt(l, r));

        // Abort by reset at cycle 30, restart at cycle 32.
        seen = 0;
        for (int c = 0; c < 32; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            L_in  = $urandom;
            R_in  = $urandom;
            reset = (c == 30);
            @(negedge clk);
            if (done) seen = 1;
            if (c == 31) begin
                check("abort_results", {resultL, resultR}, 64'd0);
                check("abort_cs", {62'd0, cs_a_l, cs_b_l}, 64'd3);
            end
        end
        check("abort_no_done", {63'd0, seen}, 64'd0);
        l = $urandom; r = $urandom;
        run_block(l, r, 0, 0, 0, dc);
        check("restart_done_cycle", 64'(dc + 32), 64'd98);
        check("restart_result", {resultL, resultR}, model_decrypt(l, r));

`ifdef FEISTEL_DECRYPT_BIDIR_EN
        for (int i = 0; i < 10; i++) begin
            l = $urandom; r = $urandom;
            ct = model_encrypt(l, r);
            exp_q.push_back(ct);
            block_and_score("bidir_enc", l, r, 1, 0, 0);
            exp_q.push_back({l, r});
            block_and_score("bidir_dec", ct[63:32], ct[31:0], 0, 0, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/feistel_decrypt.md
Name: feistel_decrypt

Overview:
- Blowfish 16-round Feistel decryption core; inverse companion of the encryption round engine.
- Reads the expanded P-array and S-boxes from two single-port SRAMs (A and B), using the same memory map and SRAM pin conventions as the encrypt path.
- Applies P-array entries in reverse order (P17..P2 in rounds, P1/P0 in the final whitening).
- Used by the bcrypt datapath wherever a block must be inverted, e.g. self-check of the encrypt core.

Parameters:
- P_ARRAY_OFFSET, 4000, SRAM word address of P[0]; P[i] sits at P_ARRAY_OFFSET+i. P_ARRAY_OFFSET+17 must be < 4096.

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  reset; synchronous active-high
- start  input  1  begin a block; sampled only in WAIT
- L  input  32  ciphertext left half, captured at start
- R  input  32  ciphertext right half, captured at start
- addr_a  output  12  SRAM A word address
- data_a  input  32  SRAM A read data, valid the cycle after cs_a_l low
- cs_a_l, we_a_l, oe_a_l  output  1 each  SRAM A chip select, write enable, output enable (active low)
- addr_b, data_b, cs_b_l, we_b_l, oe_b_l  as SRAM A, for SRAM B
- resultL  output  32  plaintext left half
- resultR  output  32  plaintext right half
- done  output  1  one-cycle completion pulse

Behaviour:
- Memory map, both SRAMs: S0 at 0..255, S1 at 256..511, S2 at 512..767, S3 at 768..1023, P at P_ARRAY_OFFSET+0..17.
- SRAM rules:
  - Read-only: we_*_l tied 1.
  - oe_*_l equals cs_*_l.
  - cs_*_l low only in cycles that issue a read.
  - addr_* is 0 when not reading.
  - Read latency is exactly 1 cycle.
- Registers: Lr, Rr, F_r (32b), rc (5b), state. All adds are mod 2^32.
- Reset values: state=WAIT; Lr=Rr=F_r=0; rc=0; resultL=resultR=0; done=0; cs high. Reset mid-block aborts immediately with no done pulse.
- WAIT:
  - On start: Lr<=L, Rr<=R, rc<=17; read A at OFF+17; go to PXOR.
  - Otherwise stay, no reads.
- PXOR: Lr <= Lr ^ data_a (P[rc]); go to SB01.
- SB01: read A at Lr[31:24], read B at 256+Lr[23:16]; go to SB23.
- SB23: F_r <= data_a + data_b; read A at 512+Lr[15:8], read B at 768+Lr[7:0]; go to FMIX.
- FMIX:
  - Lr <= Rr ^ ((F_r ^ data_a) + data_b); Rr <= Lr.
  - If rc>2: rc<=rc-1; read A at OFF+rc-1; go to PXOR.
  - Else: read A at OFF+1 and B at OFF+0; go to FINAL.
- FINAL: resultR <= Lr ^ data_a (P1); resultL <= Rr ^ data_b (P0). This undoes the last swap. Go to DONE.
- DONE: done=1 for this cycle only; go to WAIT.
- Timing:
  - Start accepted at cycle 0; each round takes 4 cycles (PXOR, SB01, SB23, FMIX).
  - FINAL at cycle 65; done high at cycle 66.
  - resultL/resultR are valid from the done cycle and held until the next FINAL.
- start outside WAIT is ignored, with no queuing. start in the DONE cycle is also ignored.
- L/R are sampled only at the start cycle; later changes have no effect.

Optional Feature:
- Macro FEISTEL_DECRYPT_BIDIR_EN.
- Defined:
  - Adds input port `encrypt` (1b), sampled with start.
  - encrypt=1: rc starts at 0 and increments; the FMIX exit test is rc<15.
  - FINAL reads A at OFF+16 (feeds resultR) and B at OFF+17 (feeds resultL).
  - Output matches the encrypt core bit-exactly.
- Undefined: no `encrypt` port; decrypt only.

Test Plan:
- All SRAM words 0; start with L=0x01234567, R=0x89ABCDEF -> done at cycle 66; resultL=0x89ABCDEF, resultR=0x01234567.
- Only P[17]=0xFFFFFFFF, rest 0; L=0x01234567, R=0x89ABCDEF -> resultL=0x89ABCDEF, resultR=0xFEDCBA98.
- Zero-key expanded Blowfish state preloaded from model; L=0x4EF99745, R=0x6198DD78 -> resultL=0, resultR=0. 100 random blocks must match the model.
- Address trace, all-zero memory, L=R=0:
  - cycle 0: addr_a=4017
  - cycle 2: addr_a=0, addr_b=256
  - cycle 3: addr_a=512, addr_b=768
  - cycle 4: addr_a=4016
  - cycle 64: addr_a=4001, addr_b=4000
  - we_*_l always 1.
- start pulsed at cycles 10 and 66 with different L/R -> ignored: one done at cycle 66, results from the first block. Reset at cycle 30 -> state WAIT, results 0, no done pulse; a new start at cycle 32 completes at cycle 98.
- With BIDIR_EN: encrypt 0/0 with the zero-key state -> 0x4EF99745/0x6198DD78; decrypting that result returns 0/0.
